// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder. It holds the bus widths,
// the access-size encodings, the width of the latency counters and the
// byte-lane merge helper used when a write is applied.
package data_sram_responder_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int STRB_W    = DATA_W / 8;
  // Wide enough to hold LATENCY-1 for any LATENCY up to 15.
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Returns old_w with each byte lane that has its strb bit set taken from new_w.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Request and response bus between a data-side requester and the SRAM
// responder.
//   master: drives req / wr / size / wstrb / addr / wdata and receives
//           addr_ok / data_ok / rdata
//   slave : the mirror image of master
interface data_sram_responder_if;
  import data_sram_responder_pkg::*;

  logic              data_sram_req;
  logic              data_sram_wr;
  logic [1:0]        data_sram_size;
  logic [STRB_W-1:0] data_sram_wstrb;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic              data_sram_addr_ok;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

endinterface

// File: rtl/data_sram_resp_fifo.sv
// In-order response queue. Each entry holds the read data, a write flag and
// a latency down-counter. The head entry retires when its counter reaches
// zero.
//   clk, resetn : clock and synchronous active-low reset
//   i_push      : enqueue an accepted request (never asserted while o_full)
//   i_push_wr   : the accepted request is a write
//   i_push_data : array word sampled when the request was accepted
//   o_full      : OUTSTANDING entries are held
//   o_data_ok   : the head retires this cycle
//   o_rdata     : read data of the retiring head, zero otherwise
module data_sram_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_push,
  input  logic              i_push_wr,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_full,
  output logic              o_data_ok,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [OUTSTANDING-1:0] r_valid;
  logic [OUTSTANDING-1:0] r_wr;
  logic [DATA_W-1:0]    r_data [OUTSTANDING];
  logic [LAT_CNT_W-1:0] r_cnt  [OUTSTANDING];
  logic                 w_retire;

  // Gating with resetn keeps data_ok low during the reset cycle itself,
  // before the valid bits have been cleared.
  assign w_retire  = resetn && r_valid[r_rd_ptr] && (r_cnt[r_rd_ptr] == '0);
  assign o_full    = (r_count == CNT_W'(OUTSTANDING));
  assign o_data_ok = w_retire;
  assign o_rdata   = (w_retire && !r_wr[r_rd_ptr]) ? r_data[r_rd_ptr] : '0;

  // Payload and counters carry no reset; the valid bits alone decide
  // whether an entry is live.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (r_valid[i] && (r_cnt[i] != '0)) r_cnt[i] <= r_cnt[i] - LAT_CNT_W'(1);
      end
      if (w_retire) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr[r_wr_ptr]    <= i_push_wr;
        r_data[r_wr_ptr]  <= i_push_data;
        r_cnt[r_wr_ptr]   <= LAT_CNT_W'(LATENCY - 1);
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      case ({i_push, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Behavioural data SRAM with a fixed response latency and a bounded number
// of outstanding requests. Writes land in the array when they are accepted.
// Read data is sampled when the request is accepted, and responses return in
// order through data_sram_resp_fifo.
//   clk, resetn : clock and synchronous active-low reset (array not reset)
//   bus         : slave side of data_sram_responder_if
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  data_sram_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  w_idx;
  logic              w_full;
  logic              w_addr_ok;
  logic              w_accept;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused_bits;

  // Upper address bits alias onto the array; the byte offset is ignored.
  assign w_idx     = bus.data_sram_addr[IDX_W+1:2];
  // The full check uses the registered count, so a retiring head does not
  // free a slot until the following cycle.
  assign w_addr_ok = resetn && !w_full;
  assign w_accept  = bus.data_sram_req && w_addr_ok;
  // This is the pre-write value, so a read is unaffected by any later write.
  assign w_rd_word = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_accept && bus.data_sram_wr) begin
      r_mem[w_idx] <= merge_lanes(r_mem[w_idx], bus.data_sram_wdata, bus.data_sram_wstrb);
    end
  end

  data_sram_resp_fifo #(
    .LATENCY     (LATENCY),
    .OUTSTANDING (OUTSTANDING)
  ) u_resp_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_accept),
    .i_push_wr   (bus.data_sram_wr),
    .i_push_data (w_rd_word),
    .o_full      (w_full),
    .o_data_ok   (bus.data_sram_data_ok),
    .o_rdata     (bus.data_sram_rdata)
  );

  assign bus.data_sram_addr_ok = w_addr_ok;

  // The size field is informational only, and these address bits do not
  // select a word.
  assign w_unused_bits = ^{bus.data_sram_size,
                           bus.data_sram_addr[ADDR_W-1:IDX_W+2],
                           bus.data_sram_addr[1:0]};

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  localparam int LAT1 = 2;
  localparam int OUT1 = 4;
  localparam int LAT2 = 5;
  localparam int OUT2 = 4;

  logic clk;
  logic resetn;

  data_sram_responder_if if1 ();
  data_sram_responder_if if2 ();

  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT1), .OUTSTANDING(OUT1)) dut (
    .clk(clk), .resetn(resetn), .bus(if1)
  );

  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT2), .OUTSTANDING(OUT2)) dut_q (
    .clk(clk), .resetn(resetn), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model for dut: the expected responses with their due cycles,
  // and the array contents.
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t        mq[$];
  logic [31:0] mdl_mem [1024];

  logic        last_dok;
  logic [31:0] last_rd;
  logic        q_aok, q_dok;
  logic [31:0] q_rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Runs one clock cycle. It drives dut from the arguments and leaves the
  // dut_q inputs as the caller set them. It checks dut against the model,
  // captures the dut_q outputs, and then advances to the next edge.
  task automatic step(input logic req, input logic wr, input logic [3:0] strb,
                      input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_aok, exp_dok;
    logic [31:0] exp_rd;
    int          idx;
    if1.data_sram_req   = req;
    if1.data_sram_wr    = wr;
    if1.data_sram_size  = SIZE_WORD;
    if1.data_sram_wstrb = strb;
    if1.data_sram_addr  = addr;
    if1.data_sram_wdata = wdata;
    #1;
    if (!resetn) begin
      exp_aok = 1'b0; exp_dok = 1'b0; exp_rd = '0;
    end else begin
      exp_aok = (mq.size() < OUT1);
      exp_dok = (mq.size() > 0) && (mq[0].due == cyc);
      exp_rd  = exp_dok ? mq[0].data : 32'h0;
    end
    check("addr_ok", {31'b0, if1.data_sram_addr_ok}, {31'b0, exp_aok});
    check("data_ok", {31'b0, if1.data_sram_data_ok}, {31'b0, exp_dok});
    check("rdata",   if1.data_sram_rdata, exp_rd);
    last_dok = if1.data_sram_data_ok;
    last_rd  = if1.data_sram_rdata;
    q_aok    = if2.data_sram_addr_ok;
    q_dok    = if2.data_sram_data_ok;
    q_rd     = if2.data_sram_rdata;
    if (!resetn) begin
      mq.delete();
    end else begin
      if (exp_dok) void'(mq.pop_front());
      if (req && exp_aok) begin
        idx = int'((addr >> 2) % 1024);
        if (wr) begin
          mq.push_back('{cyc + LAT1, 32'h0});
          for (int b = 0; b < 4; b++)
            if (strb[b]) mdl_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          mq.push_back('{cyc + LAT1, mdl_mem[idx]});
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Sends n requests to dut_q, holding req until each one is accepted. It
  // records the cycle of every acceptance and of every response, counted from
  // the start of the burst.
  int          acc_cyc [8];
  int          rsp_cyc [8];
  logic [31:0] rsp_dat [8];

  task automatic q_burst(input logic wr, input int n, output int got);
    int sent;
    sent = 0; got = 0;
    for (int c = 0; c < 60 && got < n; c++) begin
      if2.data_sram_req   = (sent < n);
      if2.data_sram_wr    = wr;
      if2.data_sram_wstrb = 4'hF;
      if2.data_sram_addr  = 32'h40 + 32'(4 * sent);
      if2.data_sram_wdata = 32'hC0DE0000 + 32'(sent);
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (q_dok && got < 8) begin
        rsp_cyc[got] = c; rsp_dat[got] = q_rd; got++;
      end
      if (if2.data_sram_req && q_aok && sent < 8) begin
        acc_cyc[sent] = c; sent++;
      end
    end
    if2.data_sram_req = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 13;
  vec_t tv [NV];

  initial begin
    logic [31:0] rq[$];
    int          lat, got, n_q_dok;
    logic        seen;

    tv[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 32'h0};
    tv[1]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'h1234_5678};
    tv[2]  = '{1'b1, 4'hF, 32'h0000_0104, 32'h0000_0000, 32'h0};
    tv[3]  = '{1'b1, 4'h5, 32'h0000_0104, 32'hAABB_CCDD, 32'h0};
    tv[4]  = '{1'b0, 4'h0, 32'h0000_0104, 32'h0,         32'h00BB_00DD};
    tv[5]  = '{1'b1, 4'hF, 32'h0000_1000, 32'h5A5A_5A5A, 32'h0};
    tv[6]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h5A5A_5A5A};
    tv[7]  = '{1'b1, 4'hF, 32'h0000_0108, 32'h1111_1111, 32'h0};
    tv[8]  = '{1'b1, 4'h0, 32'h0000_0108, 32'hFFFF_FFFF, 32'h0};
    tv[9]  = '{1'b1, 4'hA, 32'h0000_0108, 32'hAABB_CCDD, 32'h0};
    tv[10] = '{1'b0, 4'h0, 32'h0000_010B, 32'h0,         32'hAA11_CC11};
    tv[11] = '{1'b1, 4'hF, 32'hFFFF_F10C, 32'h0BAD_F00D, 32'h0};
    tv[12] = '{1'b0, 4'h0, 32'h0000_010C, 32'h0,         32'h0BAD_F00D};

    resetn = 1'b0;
    if2.data_sram_req = 1'b0; if2.data_sram_wr = 1'b0; if2.data_sram_size = SIZE_WORD;
    if2.data_sram_wstrb = 4'h0; if2.data_sram_addr = '0; if2.data_sram_wdata = '0;
    if1.data_sram_req = 1'b0; if1.data_sram_wr = 1'b0; if1.data_sram_size = SIZE_WORD;
    if1.data_sram_wstrb = 4'h0; if1.data_sram_addr = '0; if1.data_sram_wdata = '0;
    @(posedge clk);
    #1;
    idle(2);
    resetn = 1'b1;
    idle(1);

    // Table vectors: one transaction at a time, each answered after LAT1 cycles.
    for (int v = 0; v < NV; v++) begin
      step(1'b1, tv[v].wr, tv[v].strb, tv[v].addr, tv[v].wdata);
      lat = 0; seen = 1'b0;
      for (int k = 1; k <= 8 && !seen; k++) begin
        idle(1);
        if (last_dok) begin seen = 1'b1; lat = k; end
      end
      check("vec_latency", 32'(lat), 32'(LAT1));
      check("vec_rdata", seen ? last_rd : 32'hDEAD_BEEF, tv[v].exp);
    end

    // A read, then a write to the same address, then another read, all back to back.
    step(1'b1, 1'b1, 4'hF, 32'h200, 32'h1);
    idle(4);
    rq.delete();
    step(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);  if (last_dok) rq.push_back(last_rd);
    step(1'b1, 1'b1, 4'hF, 32'h200, 32'h2);  if (last_dok) rq.push_back(last_rd);
    step(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);  if (last_dok) rq.push_back(last_rd);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      if (last_dok) rq.push_back(last_rd);
    end
    check("rw_count", 32'(rq.size()), 32'd3);
    check("rw_old",   rq.size() > 0 ? rq[0] : 32'hDEAD_BEEF, 32'h1);
    check("rw_wr",    rq.size() > 1 ? rq[1] : 32'hDEAD_BEEF, 32'h0);
    check("rw_new",   rq.size() > 2 ? rq[2] : 32'hDEAD_BEEF, 32'h2);

    // dut_q has a long latency. The first four requests are accepted at once,
    // and the fifth waits until the cycle after the head has retired.
    q_burst(1'b1, 5, got);
    check("qw_count", 32'(got), 32'd5);
    for (int i = 0; i < 5 && i < got; i++) check("qw_rdata_zero", rsp_dat[i], 32'h0);
    q_burst(1'b0, 5, got);
    check("qr_count", 32'(got), 32'd5);
    for (int i = 0; i < 4; i++) check("qr_acc_cycle", 32'(acc_cyc[i]), 32'(i));
    check("qr_acc5_cycle", 32'(acc_cyc[4]), 32'(LAT2 + 1));
    for (int i = 0; i < 4; i++) check("qr_rsp_cycle", 32'(rsp_cyc[i]), 32'(LAT2 + i));
    check("qr_rsp5_cycle", 32'(rsp_cyc[4]), 32'(2 * LAT2 + 1));
    for (int i = 0; i < 5 && i < got; i++)
      check("qr_rdata", rsp_dat[i], 32'hC0DE0000 + 32'(i));

    // Reset with three requests outstanding on dut_q.
    for (int c = 0; c < 3; c++) begin
      if2.data_sram_req = 1'b1; if2.data_sram_wr = 1'b0;
      if2.data_sram_addr = 32'h40 + 32'(4 * c);
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      check("rst_pre_accept", {31'b0, q_aok}, 32'h1);
    end
    if2.data_sram_req = 1'b0;
    resetn = 1'b0;
    idle(1);
    check("rst_addr_ok", {31'b0, q_aok}, 32'h0);
    check("rst_data_ok", {31'b0, q_dok}, 32'h0);
    check("rst_rdata",   q_rd, 32'h0);
    resetn = 1'b1;
    idle(1);
    check("rst_addr_ok_after", {31'b0, q_aok}, 32'h1);
    n_q_dok = 0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      if (q_dok) n_q_dok++;
    end
    check("rst_no_stale_rsp", 32'(n_q_dok), 32'd0);

    // Random traffic on dut, checked against the model, with one reset in the middle.
    for (int w = 0; w < 16; w++) step(1'b1, 1'b1, 4'hF, 32'h300 + 32'(4 * w), $urandom);
    idle(4);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'h300 + 32'(4 * $urandom_range(0, 15)) + (32'($urandom_range(0, 3)) << 12)
          + 32'($urandom_range(0, 3));
      if (i == 200) begin
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             a, $urandom);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning backing-array size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok (legal range 1..15).
REQ-003 SHALL have parameter OUTSTANDING, default 4, meaning maximum accepted-but-unanswered requests (power of two, 2..8).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port resetn, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port data_sram_req, input, 1, meaning request valid.
REQ-007 SHALL have port data_sram_wr, input, 1, meaning 1 = write, 0 = read.
REQ-008 SHALL have port data_sram_size, input, 2, meaning 0 = byte, 1 = half, 2 = word (informational only).
REQ-009 SHALL have port data_sram_wstrb, input, 4, meaning byte-lane write enables.
REQ-010 SHALL have port data_sram_addr, input, 32, meaning byte address.
REQ-011 SHALL have port data_sram_wdata, input, 32, meaning write data, lane-aligned.
REQ-012 SHALL have port data_sram_addr_ok, output, 1, meaning request accepted this cycle when high with req.
REQ-013 SHALL have port data_sram_data_ok, output, 1, meaning one response returned this cycle.
REQ-014 SHALL have port data_sram_rdata, output, 32, meaning full-word read data, valid with data_ok.

Function
REQ-015 SHALL accept a request in any cycle where data_sram_req and data_sram_addr_ok are both high.
REQ-016 SHALL drive data_sram_addr_ok = resetn-deasserted AND outstanding count < OUTSTANDING; no pass-through when full, even if a response retires the same cycle.
REQ-017 SHALL index the array by addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap), addr[1:0] ignored.
REQ-018 SHALL perform writes at acceptance, updating only lanes with wstrb bit set; size is not checked.
REQ-019 SHALL sample read data from the array at acceptance, so a later-accepted write never affects an earlier-accepted read.
REQ-020 SHALL enqueue each accepted request into an in-order response FIFO entry holding read data, write flag and a down-counter loaded with LATENCY-1.
REQ-021 SHALL decrement every valid entry's nonzero counter each cycle.
REQ-022 SHALL assert data_sram_data_ok exactly when the head entry is valid with counter zero, retiring it that cycle; a request accepted in cycle T answers no earlier than cycle T+LATENCY.
REQ-023 SHALL return at most one response per cycle, strictly in acceptance order; back-to-back requests yield back-to-back data_ok.
REQ-024 SHALL answer writes with data_ok and rdata = 0.
REQ-025 SHALL drive data_sram_rdata = 0 whenever data_sram_data_ok is low.
REQ-026 SHALL treat simultaneous accept and retire as count unchanged; pointers wrap modulo OUTSTANDING.
REQ-027 SHALL impose no backpressure on responses; the requester must consume every data_ok.

Reset
REQ-028 SHALL, while resetn is low at a clock edge, clear FIFO pointers, count and all entry valid bits; addr_ok, data_ok and rdata read 0 during reset.
REQ-029 SHALL discard all outstanding requests on reset mid-operation; no data_ok for them after resetn rises.
REQ-030 SHALL not reset the backing-array contents.
REQ-031 SHALL assert addr_ok in the first cycle after resetn rises.

Structure
REQ-032 SHALL place size encodings (BYTE/HALF/WORD) and data/address widths in the shared header package.
REQ-033 SHALL implement the response FIFO with latency counters as one sub-module, data_sram_resp_fifo; the array and write-lane logic stay in the top.

Verification
REQ-034 SHALL cover single read: preload word 0x100 = 0x12345678, read addr 0x100 accepted cycle T -> data_ok cycle T+2, rdata 0x12345678.
REQ-035 SHALL cover partial write: write addr 0x104 wdata 0xAABBCCDD wstrb 0b0101 over 0x00000000, then read -> 0x00BB00DD.
REQ-036 SHALL cover full queue: 5 back-to-back reads, OUTSTANDING 4 -> addr_ok low on the 5th until a data_ok has retired the head, then 5 in-order responses.
REQ-037 SHALL cover read-then-write same address: read 0x200 (old 0x1), then write 0x2 -> read returns 0x1; subsequent read returns 0x2.
REQ-038 SHALL cover reset mid-operation: 3 outstanding, resetn low one cycle -> zero data_ok afterward; addr_ok high the next cycle.
REQ-039 SHALL cover address wrap: DEPTH_WORDS 1024, write 0x1000 with 0x5A5A5A5A -> read 0x0 returns 0x5A5A5A5A.
